sa_tile_scheduler: RTL and testbench
====================================

// Module: sa_tile_scheduler
// PURPOSE
//   Sequences ONE external 8x8 systolic array to compute a full NxN int8 matmul C = A*B with 32-bit accumulation.
//   Captures A/B on start, issues (N/T)^3 tile passes, and accumulates partial tiles into an internal C buffer.
//   Sits between the NPU command layer and a shared systolicArray8x8 instance.
//   Replaces the 4-array, 2-phase arrangement with a single time-multiplexed array.
// PARAMETERS
//   N        16   full matrix dimension; must be a multiple of T
//   T        8    tile dimension; equals the systolic array size
//   ACC_W    32   accumulator / result element width
//   TIMEOUT  64   max cycles in WAIT for i_sa_valid before abort (>=2)
// PORTS
//   i_clk       in   1              clock, all logic on rising edge
//   i_arst      in   1              reset, synchronous, active-high
//   i_start     in   1              start request; sampled only in IDLE
//   i_a         in   N*N*8          signed A[row][col], captured on accepted start
//   i_b         in   N*N*8          signed B[row][col], captured on accepted start
//   o_busy      out  1              high in every state except IDLE
//   o_done      out  1              1-cycle pulse: o_c holds the complete result
//   o_error     out  1              timeout flag; set on abort, cleared on next accepted start
//   o_c         out  N*N*ACC_W      signed result C[row][col], registered
//   o_sa_a      out  T*T*8          A tile to the array, registered
//   o_sa_b      out  T*T*8          B tile to the array, registered
//   o_sa_valid  out  1              1-cycle issue pulse to the array
//   i_sa_c      in   T*T*ACC_W      signed tile product from the array
//   i_sa_valid  in   1              array result valid; honoured only in WAIT
// BEHAVIOUR
//   Reset (sync): state=IDLE, all outputs 0, o_c=0, operand regs=0, counters=0. Reset overrides any in-flight op.
//   Counters ti, tj, k in [0, N/T-1]. Pass order: ti outer, tj middle, k inner (row-major over output tiles).
//   Pass operands: o_sa_a = A[ti*T +: T][k*T +: T]; o_sa_b = B[k*T +: T][tj*T +: T].
//   FSM states and transitions:
//     IDLE:   i_start=1 -> latch i_a/i_b, zero ti/tj/k, clear o_error, go ISSUE.
//             i_start=0 -> stay. o_c keeps the previous result.
//     ISSUE:  o_sa_a/o_sa_b loaded at entry and held stable through WAIT.
//             o_sa_valid=1 for exactly this cycle; wait timer cleared; go WAIT.
//     WAIT:   i_sa_valid=1 -> update C tile (ti,tj):
//               k==0: C_tile = i_sa_c (overwrite)
//               k>0:  C_tile += i_sa_c
//             then advance k, tj, ti with carry.
//               last pass (all counters at max): go DONE.
//               otherwise: go ISSUE.
//             Timer hits TIMEOUT-1 with no i_sa_valid -> o_error=1, go IDLE, no o_done.
//             On abort o_c is partially updated and undefined.
//     DONE:   o_done=1 for this one cycle; go IDLE.
//   Latency: array response L cycles after issue (i_sa_valid in the cycle ISSUE+L, L>=1) gives L+1 cycles per pass.
//     o_done is high 1+(N/T)^3*(L+1) cycles after the start-accept edge (33 for N=16, T=8, L=3).
//   Ignored inputs: i_start while o_busy=1; i_sa_valid in IDLE/ISSUE/DONE.
//   Operands are latched, so i_a/i_b may change freely after the start is accepted.
//   Arithmetic: signed two's complement, wraps modulo 2^ACC_W, no saturation.
//     Overflow cannot occur for N=16 and ACC_W=32.
//   o_c is updated in place during a run; it is valid only at o_done and until the next accepted start.
// TESTING
//   Bench uses an array stub with fixed latency L=3 computing the exact tile product.
//   T1 A=identity, B[r][c]=r*16+c-128, start -> o_done at cycle 33, o_c==B, o_error=0.
//   T2 A=B=all -128 -> every o_c element = 262144. T3 A=all 1, B=all -1 -> every o_c element = -16.
//   T4 i_start held high for 40 cycles -> exactly one run, one o_done pulse; o_sa_valid pulses exactly 8 times.
//   T5 stub never returns i_sa_valid -> o_error=1 64 cycles after issue, FSM in IDLE, o_done never asserted.
//      A following good start clears o_error and completes.
//   T6 i_arst during pass 4 -> next cycle all outputs 0, o_busy=0.
//      Stray i_sa_valid in IDLE leaves o_c unchanged.

Source files
------------

// File: rtl/sa_tile_scheduler_if.sv
// Command-side and array-side signals of the tile scheduler, bundled for port connection.
// master = scheduler, slave = command layer plus the shared systolic array.
interface sa_tile_scheduler_if #(
    parameter int N     = 16,
    parameter int T     = 8,
    parameter int ACC_W = 32
);
    logic                   i_start;
    logic [N*N*8-1:0]       i_a;
    logic [N*N*8-1:0]       i_b;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_error;
    logic [N*N*ACC_W-1:0]   o_c;
    logic [T*T*8-1:0]       o_sa_a;
    logic [T*T*8-1:0]       o_sa_b;
    logic                   o_sa_valid;
    logic [T*T*ACC_W-1:0]   i_sa_c;
    logic                   i_sa_valid;

    modport master (
        input  i_start, i_a, i_b, i_sa_c, i_sa_valid,
        output o_busy, o_done, o_error, o_c, o_sa_a, o_sa_b, o_sa_valid
    );

    modport slave (
        output i_start, i_a, i_b, i_sa_c, i_sa_valid,
        input  o_busy, o_done, o_error, o_c, o_sa_a, o_sa_b, o_sa_valid
    );
endinterface

// File: rtl/sa_tile_scheduler.sv
// Time-multiplexes one TxT systolic array over an NxN int8 matmul, accumulating tiles into C.
// Matrices are flattened row-major: element [row][col] sits at index row*DIM+col.
module sa_tile_scheduler #(
    parameter int N       = 16,
    parameter int T       = 8,
    parameter int ACC_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    sa_tile_scheduler_if.master   bus
);
    localparam int NT  = N / T;
    localparam int CW  = (NT > 1) ? $clog2(NT) : 1;
    localparam int TMW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [N*N*8-1:0]       r_a, r_b, w_src_a, w_src_b;
    logic [N*N*ACC_W-1:0]   r_c, w_c_nxt;
    logic [T*T*8-1:0]       r_sa_a, r_sa_b, w_tile_a, w_tile_b;
    logic [CW-1:0]          r_ti, r_tj, r_k, w_ti_nxt, w_tj_nxt, w_k_nxt;
    logic [TMW-1:0]         r_timer;
    logic                   r_error;
    logic                   w_accept, w_accum, w_last, w_enter_issue, w_abort;

    assign w_accept      = (r_state == S_IDLE) && bus.i_start;
    assign w_accum       = (r_state == S_WAIT) && bus.i_sa_valid;
    assign w_last        = (r_ti == CW'(NT-1)) && (r_tj == CW'(NT-1)) && (r_k == CW'(NT-1));
    assign w_enter_issue = w_accept || (w_accum && !w_last);
    assign w_abort       = (r_state == S_WAIT) && !bus.i_sa_valid && (r_timer == TMW'(TIMEOUT-1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.i_start) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.i_sa_valid) w_state_nxt = w_last ? S_DONE : S_ISSUE;
                else if (w_abort)   w_state_nxt = S_IDLE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // k innermost, then tj, then ti; a fresh start restarts at tile (0,0,0).
    always_comb begin
        w_ti_nxt = r_ti;
        w_tj_nxt = r_tj;
        w_k_nxt  = r_k;
        if (r_state == S_IDLE) begin
            w_ti_nxt = '0;
            w_tj_nxt = '0;
            w_k_nxt  = '0;
        end else if (r_k == CW'(NT-1)) begin
            w_k_nxt = '0;
            if (r_tj == CW'(NT-1)) begin
                w_tj_nxt = '0;
                w_ti_nxt = r_ti + CW'(1);
            end else begin
                w_tj_nxt = r_tj + CW'(1);
            end
        end else begin
            w_k_nxt = r_k + CW'(1);
        end
    end

    // Tiles are cut on the edge that enters ISSUE, straight from i_a/i_b on the start edge.
    assign w_src_a = (r_state == S_IDLE) ? bus.i_a : r_a;
    assign w_src_b = (r_state == S_IDLE) ? bus.i_b : r_b;

    always_comb begin
        w_tile_a = '0;
        w_tile_b = '0;
        for (int r = 0; r < T; r++) begin
            for (int c = 0; c < T; c++) begin
                w_tile_a[(r*T+c)*8 +: 8] =
                    w_src_a[((int'(w_ti_nxt)*T + r)*N + int'(w_k_nxt)*T + c)*8 +: 8];
                w_tile_b[(r*T+c)*8 +: 8] =
                    w_src_b[((int'(w_k_nxt)*T + r)*N + int'(w_tj_nxt)*T + c)*8 +: 8];
            end
        end
    end

    always_comb begin
        w_c_nxt = r_c;
        if (w_accum) begin
            for (int r = 0; r < T; r++) begin
                for (int c = 0; c < T; c++) begin
                    w_c_nxt[((int'(r_ti)*T + r)*N + int'(r_tj)*T + c)*ACC_W +: ACC_W] =
                        ((r_k == '0) ? ACC_W'(0)
                                     : r_c[((int'(r_ti)*T + r)*N + int'(r_tj)*T + c)*ACC_W +: ACC_W])
                        + bus.i_sa_c[(r*T+c)*ACC_W +: ACC_W];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_sa_a  <= '0;
            r_sa_b  <= '0;
            r_ti    <= '0;
            r_tj    <= '0;
            r_k     <= '0;
            r_timer <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_c     <= w_c_nxt;
            if (w_accept) begin
                r_a     <= bus.i_a;
                r_b     <= bus.i_b;
                r_error <= 1'b0;
            end
            if (w_abort) r_error <= 1'b1;
            // Timer reads 0 during ISSUE and counts cycles since the issue pulse.
            if (w_enter_issue) begin
                r_sa_a  <= w_tile_a;
                r_sa_b  <= w_tile_b;
                r_ti    <= w_ti_nxt;
                r_tj    <= w_tj_nxt;
                r_k     <= w_k_nxt;
                r_timer <= '0;
            end else if (r_state == S_ISSUE || r_state == S_WAIT) begin
                r_timer <= r_timer + TMW'(1);
            end
        end
    end

    assign bus.o_busy     = (r_state != S_IDLE);
    assign bus.o_done     = (r_state == S_DONE);
    assign bus.o_sa_valid = (r_state == S_ISSUE);
    assign bus.o_error    = r_error;
    assign bus.o_c        = r_c;
    assign bus.o_sa_a     = r_sa_a;
    assign bus.o_sa_b     = r_sa_b;
endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Scoreboarded bench for sa_tile_scheduler: full-matrix reference model, fixed-latency array stub.
module tb_sa_tile_scheduler;
    localparam int N = 16, T = 8, ACC_W = 32, TIMEOUT = 64, L = 3;
    localparam int NT = N / T;
    localparam int PASSES = NT * NT * NT;

    typedef struct {
        logic [N*N*ACC_W-1:0] c;
        int                   done_cyc;
    } exp_t;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    sa_tile_scheduler_if #(.N(N), .T(T), .ACC_W(ACC_W)) bus ();
    sa_tile_scheduler #(.N(N), .T(T), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk (clk),
        .i_arst(arst),
        .bus   (bus)
    );

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0, errors = 0, cyc = 0, done_cnt = 0, issue_cnt = 0, pend = 0;
    bit   mute = 1'b0, stray = 1'b0;
    int   ma[N][N], mb[N][N];
    logic [N*N*ACC_W-1:0] last_c = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic chk_c(input string name, input logic [N*N*ACC_W-1:0] got,
                         input logic [N*N*ACC_W-1:0] want);
        int bad;
        bad = -1;
        checks++;
        for (int i = N*N-1; i >= 0; i--)
            if (got[i*ACC_W +: ACC_W] !== want[i*ACC_W +: ACC_W]) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: C[%0d][%0d] got %0d want %0d", name, bad / N, bad % N,
                     $signed(got[bad*ACC_W +: ACC_W]), $signed(want[bad*ACC_W +: ACC_W]));
        end
    endtask

    function automatic logic [T*T*ACC_W-1:0] tile_prod(input logic [T*T*8-1:0] a,
                                                       input logic [T*T*8-1:0] b);
        logic [T*T*ACC_W-1:0] p;
        int s, av, bv;
        p = '0;
        for (int r = 0; r < T; r++)
            for (int c = 0; c < T; c++) begin
                s = 0;
                for (int m = 0; m < T; m++) begin
                    av = int'($signed(a[(r*T+m)*8 +: 8]));
                    bv = int'($signed(b[(m*T+c)*8 +: 8]));
                    s += av * bv;
                end
                p[(r*T+c)*ACC_W +: ACC_W] = ACC_W'(s);
            end
        return p;
    endfunction

    // Array stub: result valid L cycles after the issue pulse; can be muted or fire a stray valid.
    always @(negedge clk) begin
        bus.i_sa_valid = 1'b0;
        if (arst) pend = 0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) bus.i_sa_valid = 1'b1;
        end
        if (stray) begin
            for (int i = 0; i < T*T*ACC_W/32; i++) bus.i_sa_c[i*32 +: 32] = $urandom;
            bus.i_sa_valid = 1'b1;
            stray = 1'b0;
        end
        if (!arst && bus.o_sa_valid) begin
            issue_cnt++;
            if (!mute) begin
                pend = L;
                bus.i_sa_c = tile_prod(bus.o_sa_a, bus.o_sa_b);
            end
        end
    end

    // Monitor: every o_done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!arst && bus.o_done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got o_done=1 at cycle %0d want 0", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk_c("result", bus.o_c, mon_e.c);
                chk("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
                chk("error_at_done", 64'(bus.o_error), 64'd0);
                last_c = mon_e.c;
            end
        end
    end

    task automatic scramble_inputs();
        for (int i = 0; i < N*N*8/32; i++) begin
            bus.i_a[i*32 +: 32] = $urandom;
            bus.i_b[i*32 +: 32] = $urandom;
        end
    endtask

    task automatic start_run(input bit hold, input bit push, output int t0);
        logic [N*N*8-1:0]     pa, pb;
        logic [N*N*ACC_W-1:0] pc;
        exp_t                 e;
        int                   s;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                pa[(r*N+c)*8 +: 8] = 8'(ma[r][c]);
                pb[(r*N+c)*8 +: 8] = 8'(mb[r][c]);
                s = 0;
                for (int m = 0; m < N; m++) s += ma[r][m] * mb[m][c];
                pc[(r*N+c)*ACC_W +: ACC_W] = ACC_W'(s);
            end
        @(posedge clk); #1;
        bus.i_a = pa;
        bus.i_b = pb;
        bus.i_start = 1'b1;
        t0 = cyc;
        if (push) begin
            e.c = pc;
            e.done_cyc = t0 + 1 + PASSES * (L + 1);
            exp_q.push_back(e);
        end
        if (!hold) begin
            @(posedge clk); #1;
            bus.i_start = 1'b0;
            scramble_inputs();
        end
    endtask

    // Returns right at the posedge after o_done was seen (no #1), or after the budget runs out.
    task automatic wait_done(input string name, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
        if (done_cnt == d0) chk({name, "_done_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic fill(input int mode);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                case (mode)
                    1: begin ma[r][c] = (r == c) ? 1 : 0; mb[r][c] = r*16 + c - 128; end
                    2: begin ma[r][c] = -128; mb[r][c] = -128; end
                    3: begin ma[r][c] = 1; mb[r][c] = -1; end
                    default: begin
                        ma[r][c] = int'($urandom_range(255)) - 128;
                        mb[r][c] = int'($urandom_range(255)) - 128;
                    end
                endcase
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},     64'(bus.o_busy), 64'd0);
        chk({tag, "_done"},     64'(bus.o_done), 64'd0);
        chk({tag, "_error"},    64'(bus.o_error), 64'd0);
        chk({tag, "_sa_valid"}, 64'(bus.o_sa_valid), 64'd0);
        chk({tag, "_sa_a_any"}, 64'(|bus.o_sa_a), 64'd0);
        chk({tag, "_sa_b_any"}, 64'(|bus.o_sa_b), 64'd0);
        chk_c({tag, "_c"}, bus.o_c, '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got %0d errors so far", errors);
        $fatal(1);
    end

    initial begin
        int t0, i0;
        bus.i_start = 1'b0;
        bus.i_a = '0;
        bus.i_b = '0;
        bus.i_sa_c = '0;
        bus.i_sa_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        arst = 1'b0;

        // T1..T3 directed, then a few random matrices.
        for (int m = 1; m <= 6; m++) begin
            fill(m);
            start_run(1'b0, 1'b1, t0);
            wait_done($sformatf("run%0d", m), 100);
            #1;
        end

        // T4: start held across the whole run triggers a single run of PASSES issues.
        fill(0);
        i0 = issue_cnt;
        start_run(1'b1, 1'b1, t0);
        wait_done("held_start", 100);
        #1;
        bus.i_start = 1'b0;
        chk("held_start_issues", 64'(issue_cnt - i0), 64'(PASSES));
        repeat (5) @(posedge clk);
        #1;
        chk("held_start_idle", 64'(bus.o_busy), 64'd0);

        // Stray array valid in IDLE must not touch the finished result.
        stray = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_c("stray_after_run", bus.o_c, last_c);

        // T5: array never answers -> abort with o_error exactly TIMEOUT cycles after issue.
        mute = 1'b1;
        fill(0);
        start_run(1'b0, 1'b0, t0);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        chk("timeout_pre_error", 64'(bus.o_error), 64'd0);
        chk("timeout_pre_busy", 64'(bus.o_busy), 64'd1);
        @(posedge clk); #1;
        chk("timeout_error", 64'(bus.o_error), 64'd1);
        chk("timeout_idle", 64'(bus.o_busy), 64'd0);
        repeat (4) @(posedge clk);
        mute = 1'b0;
        fill(0);
        start_run(1'b0, 1'b1, t0);
        chk("error_cleared", 64'(bus.o_error), 64'd0);
        wait_done("after_timeout", 100);
        #1;

        // T6: reset in the middle of pass 4.
        fill(0);
        i0 = issue_cnt;
        start_run(1'b0, 1'b1, t0);
        for (int i = 0; i < 100 && issue_cnt < i0 + 4; i++) @(posedge clk);
        chk("pass4_reached", 64'(issue_cnt - i0 >= 4), 64'd1);
        #1;
        arst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk_all_zero("midrun_reset");
        arst = 1'b0;
        stray = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_c("stray_after_reset", bus.o_c, '0);

        fill(0);
        start_run(1'b0, 1'b1, t0);
        wait_done("after_reset", 100);
        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
